frame_store: RTL and testbench

Multi-frame packet buffer placed after `frame_receiver`. It writes received bytes into a circular byte RAM and commits each frame with a `{start, length}` descriptor only when the frame ended with a correct CRC and no error. Bad, runt, oversize and overflowing frames are rewound and discarded. Committed frames are played out in arrival order on a valid/ready byte stream with start-of-frame and end-of-frame markers.

---
 rtl/frame_store_pkg.sv | 20 ++
 rtl/frame_store_ram.sv | 24 ++
 rtl/frame_store.sv | 259 +++++++++++++++++++++++++
 tb/tb_frame_store.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_store_pkg.sv
// frame_store_pkg: read FSM states and drop-reason bit positions.
// Statistics counters in frame_store are enabled by FRAME_STORE_STATS_EN.
package frame_store_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } rd_state_e;

   // Bit positions in the per-frame drop-reason vector
   localparam int DR_CRC  = 0;
   localparam int DR_ERR  = 1;
   localparam int DR_OVF  = 2;
   localparam int DR_OVS  = 3;
   localparam int DR_RUNT = 4;
   localparam int DR_FULL = 5;
   localparam int DR_NUM  = 6;

endpackage

// File: rtl/frame_store_ram.sv
// frame_store_ram: byte RAM, one write port and one registered read port.
// The read register holds its value while re is low.
module frame_store_ram #(
   parameter int pADDR_W = 12
) (
   input  logic               iclk,
   input  logic               we,
   input  logic [pADDR_W-1:0] waddr,
   input  logic [7:0]         wdata,
   input  logic               re,
   input  logic [pADDR_W-1:0] raddr,
   output logic [7:0]         rdata
);

   logic [7:0] mem [2**pADDR_W];

   always_ff @(posedge iclk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/frame_store.sv
// frame_store: circular multi-frame buffer, commits only clean frames.
// Define FRAME_STORE_STATS_EN to build the ok/drop frame counters.
module frame_store
   import frame_store_pkg::*;
#(
   parameter int pADDR_W  = 12,
   parameter int pDESC_W  = 4,
   parameter int pLEN_W   = 11,
   parameter int pMIN_LEN = 64
) (
   input  logic               iclk,
   input  logic               i_rst,
   input  logic               idv,
   input  logic [7:0]         irx_d,
   input  logic               i_error,
   input  logic               i_crc_correct,
   output logic               o_val,
   output logic [7:0]         o_data,
   output logic               o_sof,
   output logic               o_eof,
   input  logic               i_ready,
   output logic [pLEN_W-1:0]  o_len,
   output logic [pDESC_W:0]   o_frames,
   output logic [pADDR_W:0]   o_used,
   output logic [15:0]        o_drop_cnt,
   output logic [15:0]        o_ok_cnt
);

   localparam int DEPTH  = 2**pADDR_W;
   localparam int DDEPTH = 2**pDESC_W;
   localparam int SUM_W  =
      ((pADDR_W + 1 > pLEN_W) ? pADDR_W + 1 : pLEN_W) + 1;
   localparam logic [pLEN_W-1:0] MAX_LEN = '1;

   typedef struct packed {
      logic [pADDR_W-1:0] addr;
      logic [pLEN_W-1:0]  len;
   } desc_t;

   logic [pADDR_W-1:0] wr_ptr;
   logic [pADDR_W-1:0] frame_start;
   logic [pLEN_W-1:0]  cur_len;
   logic               ovf;
   logic               ovs;
   logic               in_frame;
   logic [pADDR_W:0]   used_c;
   logic [SUM_W-1:0]   used_sum;
   logic               byte_ok;
   logic               status;
   logic               commit;
   logic               full;
   logic [DR_NUM-1:0]  why;

   desc_t              fifo [DDEPTH];
   desc_t              head;
   logic [pDESC_W-1:0] fifo_wr;
   logic [pDESC_W-1:0] fifo_rd;
   logic [pDESC_W:0]   fifo_cnt;

   rd_state_e          state;
   rd_state_e          state_nx;
   logic [pADDR_W-1:0] rd_ptr;
   logic [pLEN_W-1:0]  rd_rem;
   logic [pLEN_W-1:0]  rd_len;
   logic               sof_q;
   logic               load;
   logic               ram_re;
   logic               pop;
   logic [7:0]         ram_q;
   logic [pADDR_W:0]   add_len;
   logic [pADDR_W:0]   sub_len;

   // Occupancy seen by the writer includes the frame being received
   assign used_sum = SUM_W'(used_c) + SUM_W'(cur_len);
   assign full     = (fifo_cnt == (pDESC_W+1)'(DDEPTH));
   assign status   = in_frame && !idv;
   assign byte_ok  = idv && !ovf && !ovs && (cur_len != MAX_LEN)
                     && (used_sum < SUM_W'(DEPTH));

   always_comb begin
      why           = '0;
      why[DR_CRC]   = !i_crc_correct;
      why[DR_ERR]   = i_error;
      why[DR_OVF]   = ovf;
      why[DR_OVS]   = ovs;
      why[DR_RUNT]  = (cur_len < pLEN_W'(pMIN_LEN));
      why[DR_FULL]  = full;
   end

   assign commit = status && (why == '0);

   always_ff @(posedge iclk) begin
      if (i_rst) begin
         wr_ptr      <= '0;
         frame_start <= '0;
         cur_len     <= '0;
         ovf         <= 1'b0;
         ovs         <= 1'b0;
         in_frame    <= 1'b0;
      end else begin
         in_frame <= idv;
         if (idv && !in_frame)
            frame_start <= wr_ptr;
         if (byte_ok) begin
            wr_ptr  <= wr_ptr + 1'b1;
            cur_len <= cur_len + 1'b1;
         end else if (idv && !ovf && !ovs) begin
            if (cur_len == MAX_LEN)
               ovs <= 1'b1;
            else
               ovf <= 1'b1;
         end
         if (status) begin
            cur_len <= '0;
            ovf     <= 1'b0;
            ovs     <= 1'b0;
            if (!commit)
               wr_ptr <= frame_start;
         end
      end
   end

   always_ff @(posedge iclk) begin
      if (commit)
         fifo[fifo_wr] <= '{addr: frame_start, len: cur_len};
   end

   assign head    = fifo[fifo_rd];
   assign add_len = commit ? (pADDR_W+1)'(cur_len) : '0;
   assign sub_len = pop ? (pADDR_W+1)'(rd_len) : '0;

   always_ff @(posedge iclk) begin
      if (i_rst) begin
         fifo_wr  <= '0;
         fifo_rd  <= '0;
         fifo_cnt <= '0;
         used_c   <= '0;
      end else begin
         if (commit)
            fifo_wr <= fifo_wr + 1'b1;
         if (pop)
            fifo_rd <= fifo_rd + 1'b1;
         unique case ({commit, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         used_c <= used_c + add_len - sub_len;
      end
   end

   always_ff @(posedge iclk) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      ram_re   = 1'b0;
      pop      = 1'b0;
      o_val    = 1'b0;
      unique case (state)
         IDLE: begin
            if (fifo_cnt != '0) begin
               load     = 1'b1;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            ram_re   = 1'b1;
            state_nx = STREAM;
         end
         STREAM: begin
            o_val = 1'b1;
            if (i_ready) begin
               if (rd_rem == pLEN_W'(1)) begin
                  pop      = 1'b1;
                  state_nx = IDLE;
               end else begin
                  ram_re = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // rd_rem counts bytes left including the one on o_data
   always_ff @(posedge iclk) begin
      if (i_rst) begin
         rd_ptr <= '0;
         rd_rem <= '0;
         rd_len <= '0;
         sof_q  <= 1'b0;
      end else begin
         if (load) begin
            rd_ptr <= head.addr;
            rd_rem <= head.len;
            rd_len <= head.len;
         end
         if (ram_re)
            rd_ptr <= rd_ptr + 1'b1;
         if (state == FETCH) begin
            sof_q <= 1'b1;
         end else if (o_val && i_ready) begin
            sof_q  <= 1'b0;
            rd_rem <= rd_rem - 1'b1;
         end
      end
   end

   frame_store_ram #(
      .pADDR_W(pADDR_W)
   ) u_ram (
      .iclk  (iclk),
      .we    (byte_ok && !i_rst),
      .waddr (wr_ptr),
      .wdata (irx_d),
      .re    (ram_re),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

   assign o_data   = o_val ? ram_q : 8'h00;
   assign o_sof    = o_val && sof_q;
   assign o_eof    = o_val && (rd_rem == pLEN_W'(1));
   assign o_len    = rd_len;
   assign o_frames = fifo_cnt;
   assign o_used   = used_sum[pADDR_W:0];

`ifdef FRAME_STORE_STATS_EN
   logic [15:0] ok_cnt;
   logic [15:0] drop_cnt;

   always_ff @(posedge iclk) begin
      if (i_rst) begin
         ok_cnt   <= '0;
         drop_cnt <= '0;
      end else if (status) begin
         if (commit) begin
            if (ok_cnt != 16'hFFFF)
               ok_cnt <= ok_cnt + 1'b1;
         end else if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   assign o_ok_cnt   = ok_cnt;
   assign o_drop_cnt = drop_cnt;
`else
   assign o_ok_cnt   = 16'h0000;
   assign o_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_store.sv
// tb_frame_store: randomized frames checked against a frame-level model.
// Instances: a default, b with 128-byte RAM, c with 4-entry descriptor FIFO.
module tb_frame_store;

`ifdef FRAME_STORE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic iclk = 1'b0;
   logic i_rst = 1'b1;
   logic idv = 1'b0;
   logic [7:0] irx_d = 8'h00;
   logic i_error = 1'b0;
   logic i_crc_correct = 1'b0;
   logic i_ready = 1'b0;

   logic a_val, a_sof, a_eof;
   logic [7:0] a_data;
   logic [10:0] a_len;
   logic [4:0] a_frames;
   logic [12:0] a_used;
   logic [15:0] a_drop, a_ok;

   logic b_val, b_sof, b_eof;
   logic [7:0] b_data;
   logic [10:0] b_len;
   logic [4:0] b_frames;
   logic [7:0] b_used;
   logic [15:0] b_drop, b_ok;

   logic c_val, c_sof, c_eof;
   logic [7:0] c_data;
   logic [10:0] c_len;
   logic [2:0] c_frames;
   logic [12:0] c_used;
   logic [15:0] c_drop, c_ok;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] last_frame[$];
   logic [7:0] exp_bytes[$];
   int exp_lens[$];
   bit send_done;
   int m_ok, m_drop;

   always #5 iclk = ~iclk;

   frame_store u_a (
      .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d),
      .i_error(i_error), .i_crc_correct(i_crc_correct),
      .o_val(a_val), .o_data(a_data), .o_sof(a_sof), .o_eof(a_eof),
      .i_ready(i_ready), .o_len(a_len), .o_frames(a_frames),
      .o_used(a_used), .o_drop_cnt(a_drop), .o_ok_cnt(a_ok)
   );

   frame_store #(.pADDR_W(7)) u_b (
      .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d),
      .i_error(i_error), .i_crc_correct(i_crc_correct),
      .o_val(b_val), .o_data(b_data), .o_sof(b_sof), .o_eof(b_eof),
      .i_ready(i_ready), .o_len(b_len), .o_frames(b_frames),
      .o_used(b_used), .o_drop_cnt(b_drop), .o_ok_cnt(b_ok)
   );

   frame_store #(.pDESC_W(2)) u_c (
      .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d),
      .i_error(i_error), .i_crc_correct(i_crc_correct),
      .o_val(c_val), .o_data(c_data), .o_sof(c_sof), .o_eof(c_eof),
      .i_ready(i_ready), .o_len(c_len), .o_frames(c_frames),
      .o_used(c_used), .o_drop_cnt(c_drop), .o_ok_cnt(c_ok)
   );

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   // A frame is kept only if it is clean, sized right and fits
   function automatic bit predict(int len, bit crc, bit err,
                                  int used, int nfr,
                                  int depth, int ddepth);
      return crc && !err && len >= 64 && len <= 2047
             && used + len <= depth && nfr < ddepth;
   endfunction

   task automatic do_reset();
      idv = 1'b0;
      i_error = 1'b0;
      i_crc_correct = 1'b0;
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      exp_bytes.delete();
      exp_lens.delete();
   endtask

   task automatic send_frame(input int len, input bit crc,
                             input bit err, input bit incr);
      logic [7:0] b;
      last_frame.delete();
      for (int i = 0; i < len; i++) begin
         b = incr ? 8'(i) : 8'($urandom);
         last_frame.push_back(b);
         idv = 1'b1;
         irx_d = b;
         step();
      end
      idv = 1'b0;
      irx_d = 8'h00;
      i_crc_correct = crc;
      i_error = err;
      step();
      i_crc_correct = 1'b0;
      i_error = 1'b0;
   endtask

   task automatic expect_frame();
      foreach (last_frame[i]) exp_bytes.push_back(last_frame[i]);
      exp_lens.push_back(last_frame.size());
   endtask

   // mode 0: ready high, 1: ready toggles, 2: ready random
   task automatic drain(input int mode, input int budget);
      int pos = 0;
      int cyc = 0;
      int el;
      bit hold = 1'b0;
      bit done = 1'b0;
      logic [7:0] hd, eb;
      logic hs, he;
      while (cyc < budget && !done) begin
         if (mode == 0) i_ready = 1'b1;
         else if (mode == 1) i_ready = (cyc % 2 == 0);
         else i_ready = 1'($urandom_range(0, 1));
         if (hold) begin
            n_cmp++;
            if (a_data !== hd || a_sof !== hs || a_eof !== he) begin
               n_bad++;
               $display("FAIL hold_stable: data %h sof %b eof %b, required %h %b %b",
                        a_data, a_sof, a_eof, hd, hs, he);
            end
         end
         hold = a_val && !i_ready;
         hd = a_data;
         hs = a_sof;
         he = a_eof;
         if (a_val && i_ready) begin
            n_cmp++;
            if (exp_bytes.size() == 0) begin
               n_bad++;
               $display("FAIL extra_byte: got %h, required no output", a_data);
            end else begin
               eb = exp_bytes.pop_front();
               el = exp_lens[0];
               if (a_data !== eb || a_sof !== (pos == 0) ||
                   a_eof !== (pos == el - 1) || a_len !== 11'(el)) begin
                  n_bad++;
                  $display("FAIL out_byte[%0d]: got d=%h sof=%b eof=%b len=%0d, required d=%h sof=%b eof=%b len=%0d",
                           pos, a_data, a_sof, a_eof, a_len,
                           eb, pos == 0, pos == el - 1, el);
               end
               pos++;
               if (pos == el) begin
                  pos = 0;
                  void'(exp_lens.pop_front());
               end
            end
         end
         if (send_done && exp_bytes.size() == 0 && !a_val) done = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d bytes left, required 0",
                  exp_bytes.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (a_val !== 1'b0 || a_sof !== 1'b0 || a_eof !== 1'b0 ||
          a_data !== 8'h00 || a_len !== 11'd0) begin
         n_bad++;
         $display("FAIL reset_out: val %b sof %b eof %b data %h len %0d, required 0",
                  a_val, a_sof, a_eof, a_data, a_len);
      end
      n_cmp++;
      if (a_frames !== 5'd0 || a_used !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_occ: frames %0d used %0d, required 0 0",
                  a_frames, a_used);
      end
      n_cmp++;
      if (a_drop !== 16'd0 || a_ok !== 16'd0 ||
          b_frames !== 5'd0 || c_frames !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_cnt: drop %0d ok %0d bfr %0d cfr %0d, required 0",
                  a_drop, a_ok, b_frames, c_frames);
      end
   endtask

   task automatic test_good64();
      do_reset();
      i_ready = 1'b1;
      send_frame(64, 1'b1, 1'b0, 1'b1);
      expect_frame();
      n_cmp++;
      if (a_frames !== 5'd1 || a_used !== 13'd64 || a_val !== 1'b0) begin
         n_bad++;
         $display("FAIL commit_vis: frames %0d used %0d val %b, required 1 64 0",
                  a_frames, a_used, a_val);
      end
      step();
      n_cmp++;
      if (a_val !== 1'b0) begin
         n_bad++;
         $display("FAIL fetch_gap: val %b, required 0", a_val);
      end
      step();
      n_cmp++;
      if (a_val !== 1'b1) begin
         n_bad++;
         $display("FAIL first_byte_lat: val %b, required 1", a_val);
      end
      send_done = 1'b1;
      drain(0, 500);
      n_cmp++;
      if (a_frames !== 5'd0 || a_used !== 13'd0) begin
         n_bad++;
         $display("FAIL good64_empty: frames %0d used %0d, required 0 0",
                  a_frames, a_used);
      end
   endtask

   task automatic test_bad_good();
      do_reset();
      i_ready = 1'b1;
      send_frame(100, 1'b0, 1'b0, 1'b0);
      if (predict(100, 1'b0, 1'b0, 0, 0, 4096, 16)) expect_frame();
      send_frame(70, 1'b1, 1'b0, 1'b0);
      if (predict(70, 1'b1, 1'b0, 0, 0, 4096, 16)) expect_frame();
      send_done = 1'b1;
      drain(0, 500);
      n_cmp++;
      if (a_drop !== (STATS ? 16'd1 : 16'd0) ||
          a_ok !== (STATS ? 16'd1 : 16'd0)) begin
         n_bad++;
         $display("FAIL bad_good_stats: drop %0d ok %0d, required %0d %0d",
                  a_drop, a_ok, STATS, STATS);
      end
   endtask

   task automatic test_ready_toggle();
      do_reset();
      send_frame(128, 1'b1, 1'b0, 1'b0);
      expect_frame();
      send_done = 1'b1;
      drain(1, 1000);
      n_cmp++;
      if (a_frames !== 5'd0 || a_used !== 13'd0) begin
         n_bad++;
         $display("FAIL toggle_empty: frames %0d used %0d, required 0 0",
                  a_frames, a_used);
      end
   endtask

   task automatic test_small_ram();
      int mu = 0;
      int mf = 0;
      do_reset();
      i_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         send_frame(100, 1'b1, 1'b0, 1'b0);
         if (predict(100, 1'b1, 1'b0, mu, mf, 128, 16)) begin
            mu += 100;
            mf++;
         end
      end
      n_cmp++;
      if (b_used !== 8'(mu) || b_frames !== 5'(mf)) begin
         n_bad++;
         $display("FAIL small_ram_ovf: used %0d frames %0d, required %0d %0d",
                  b_used, b_frames, mu, mf);
      end
      n_cmp++;
      if (b_ok !== (STATS ? 16'd1 : 16'd0) ||
          b_drop !== (STATS ? 16'd1 : 16'd0)) begin
         n_bad++;
         $display("FAIL small_ram_stats: ok %0d drop %0d, required %0d %0d",
                  b_ok, b_drop, STATS, STATS);
      end
   endtask

   task automatic test_desc_full();
      int mu = 0;
      int mf = 0;
      do_reset();
      i_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_frame(64, 1'b1, 1'b0, 1'b0);
         if (predict(64, 1'b1, 1'b0, mu, mf, 4096, 4)) begin
            mu += 64;
            mf++;
         end
      end
      n_cmp++;
      if (c_frames !== 3'(mf) || c_used !== 13'(mu)) begin
         n_bad++;
         $display("FAIL desc_full: frames %0d used %0d, required %0d %0d",
                  c_frames, c_used, mf, mu);
      end
      send_frame(40, 1'b1, 1'b0, 1'b0);
      if (predict(40, 1'b1, 1'b0, mu, mf, 4096, 4)) begin
         mu += 40;
         mf++;
      end
      n_cmp++;
      if (c_frames !== 3'(mf) || c_used !== 13'(mu)) begin
         n_bad++;
         $display("FAIL runt_drop: frames %0d used %0d, required %0d %0d",
                  c_frames, c_used, mf, mu);
      end
   endtask

   task automatic test_oversize();
      do_reset();
      i_ready = 1'b0;
      send_frame(2048, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (a_frames !== 5'd0 || a_used !== 13'd0) begin
         n_bad++;
         $display("FAIL ovs_drop: frames %0d used %0d, required 0 0",
                  a_frames, a_used);
      end
      send_frame(2047, 1'b1, 1'b0, 1'b0);
      if (predict(2047, 1'b1, 1'b0, 0, 0, 4096, 16)) expect_frame();
      n_cmp++;
      if (a_frames !== 5'd1 || a_used !== 13'd2047) begin
         n_bad++;
         $display("FAIL max_len_keep: frames %0d used %0d, required 1 2047",
                  a_frames, a_used);
      end
      send_done = 1'b1;
      drain(0, 3000);
   endtask

   task automatic test_reset_mid();
      int rem = 0;
      do_reset();
      i_ready = 1'b0;
      send_frame(64, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) begin
         idv = 1'b1;
         irx_d = 8'($urandom);
         i_rst = (i == 30);
         if (i > 30) rem++;
         step();
         if (i == 30) begin
            i_rst = 1'b0;
            n_cmp++;
            if (a_val !== 1'b0 || a_frames !== 5'd0 || a_used !== 13'd0) begin
               n_bad++;
               $display("FAIL mid_reset: val %b frames %0d used %0d, required 0 0 0",
                        a_val, a_frames, a_used);
            end
         end
      end
      idv = 1'b0;
      i_crc_correct = 1'b1;
      step();
      i_crc_correct = 1'b0;
      n_cmp++;
      if (a_frames !== (predict(rem, 1'b1, 1'b0, 0, 0, 4096, 16) ?
                        5'd1 : 5'd0)) begin
         n_bad++;
         $display("FAIL remainder_drop: frames %0d, required 0", a_frames);
      end
      send_frame(64, 1'b1, 1'b0, 1'b0);
      expect_frame();
      send_done = 1'b1;
      drain(0, 500);
   endtask

   task automatic test_random_b2b();
      int len;
      bit crc, err;
      do_reset();
      m_ok = 0;
      m_drop = 0;
      send_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 12; k++) begin
               len = (k == 0) ? 63 : (k == 1) ? 64 : $urandom_range(40, 220);
               crc = ($urandom_range(0, 3) != 0);
               err = ($urandom_range(0, 7) == 0);
               send_frame(len, crc, err, 1'b0);
               if (predict(len, crc, err, 0, 0, 4096, 16)) begin
                  expect_frame();
                  m_ok++;
               end else begin
                  m_drop++;
               end
               repeat ($urandom_range(0, 2)) step();
            end
            send_done = 1'b1;
         end
         drain(2, 20000);
      join
      n_cmp++;
      if (a_ok !== (STATS ? 16'(m_ok) : 16'd0) ||
          a_drop !== (STATS ? 16'(m_drop) : 16'd0)) begin
         n_bad++;
         $display("FAIL random_stats: ok %0d drop %0d, required %0d %0d",
                  a_ok, a_drop, STATS ? m_ok : 0, STATS ? m_drop : 0);
      end
      n_cmp++;
      if (a_frames !== 5'd0 || a_used !== 13'd0) begin
         n_bad++;
         $display("FAIL random_empty: frames %0d used %0d, required 0 0",
                  a_frames, a_used);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      send_done = 1'b1;
      test_reset();
      test_good64();
      test_bad_good();
      test_ready_toggle();
      test_small_ram();
      test_desc_full();
      test_oversize();
      test_reset_mid();
      test_random_b2b();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
